// File: rtl/hdlc_mon_pkg.sv
// Shared constants, check identifiers and small helpers for the HDLC Rx monitor.
package hdlc_mon_pkg;

   localparam logic [7:0] FLAG_PATTERN = 8'h7E;
   localparam int         NUM_CHECKS   = 4;

   typedef enum logic [1:0] {
      CHK_FLAG  = 2'd0,
      CHK_SPUR  = 2'd1,
      CHK_ABORT = 2'd2,
      CHK_IDLE  = 2'd3
   } chk_e;

   function automatic logic [2:0] popCount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // Lowest-numbered check wins when several fire in the same cycle.
   function automatic chk_e lowestErr(input logic [3:0] v);
      chk_e id;
      casez (v)
         4'b???1: id = CHK_FLAG;
         4'b??10: id = CHK_SPUR;
         4'b?100: id = CHK_ABORT;
         default: id = CHK_IDLE;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/hdlc_mon_delay.sv
// DEPTH-stage single-bit delay line with synchronous flush; Dout is Din delayed by DEPTH cycles.
module hdlc_mon_delay #(
   parameter int DEPTH = 2
)(
   input  logic Clk,
   input  logic Rst,
   input  logic Flush,
   input  logic Din,
   output logic Dout
);

   logic [DEPTH-1:0] stages_r;
   logic [DEPTH-1:0] shifted_s;

   // Next contents of the line: shift towards the tap, new bit enters at stage 0.
   always_comb begin
      shifted_s    = stages_r << 1;
      shifted_s[0] = Din;
   end

   // Stage registers; a flush drops every pending bit.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stages_r <= '0;
      end else if (Flush) begin
         stages_r <= '0;
      end else begin
         stages_r <= shifted_s;
      end
   end

   assign Dout = stages_r[DEPTH-1];

endmodule

// File: rtl/hdlc_rx_monitor.sv
// HDLC Rx protocol monitor: flag-detect latency, spurious flags, abort signalling, DataOut idle stability.
// Define HDLC_MON_TIMESTAMP_EN to add a cycle counter and first-error capture (FirstErrCycle/FirstErrId).
module hdlc_rx_monitor
   import hdlc_mon_pkg::*;
#(
   parameter int FLAG_LATENCY  = 2,
   parameter int ABORT_LATENCY = 1,
   parameter int IDLE_LEN      = 8,
   parameter int DATA_W        = 32,
   parameter int CNT_W         = 16
)(
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Enable,
   input  logic                  ClearCnt,
   input  logic                  Rx,
   input  logic                  Rx_FlagDetect,
   input  logic                  Rx_ValidFrame,
   input  logic                  Rx_AbortDetect,
   input  logic                  Rx_AbortSignal,
   input  logic [DATA_W-1:0]     DataOut,
   output logic [NUM_CHECKS-1:0] ErrPulse,
   output logic [NUM_CHECKS-1:0] ErrSticky,
   output logic [CNT_W-1:0]      ErrCntFlag,
   output logic [CNT_W-1:0]      ErrCntSpur,
   output logic [CNT_W-1:0]      ErrCntAbort,
   output logic [CNT_W-1:0]      ErrCntIdle,
   output logic [CNT_W+1:0]      ErrCntTotal
`ifdef HDLC_MON_TIMESTAMP_EN
   ,
   output logic [31:0]           FirstErrCycle,
   output logic [1:0]            FirstErrId
`endif
);

   localparam int IDLE_CW = $clog2(IDLE_LEN + 1);
   localparam logic [IDLE_CW-1:0] IDLE_MAX = IDLE_CW'(IDLE_LEN);

   logic [7:0]            history_r;
   logic [7:0]            window_s;
   logic                  flagHit_s;
   logic                  abortReq_s;
   logic                  flush_s;
   logic                  flagTap_s;
   logic                  abortTap_s;
   logic [NUM_CHECKS-1:0] errNow_s;
   logic [IDLE_CW-1:0]    idleCnt_r;
   logic                  idleArmed_r;
   logic [DATA_W-1:0]     capture_r;
   logic [CNT_W+2:0]      totSum_s;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c, input logic hit);
      logic [CNT_W-1:0] r;
      if (hit && (c != '1)) begin
         r = c + CNT_W'(1'b1);
      end else begin
         r = c;
      end
      return r;
   endfunction

   // Pattern match, delay-line inputs and this cycle's raw check results.
   always_comb begin
      window_s   = {history_r[6:0], Rx};
      flagHit_s  = (window_s == FLAG_PATTERN);
      abortReq_s = Rx_AbortDetect && Rx_ValidFrame;
      flush_s    = !Enable;
      errNow_s   = '0;
      if (Enable) begin
         errNow_s[CHK_FLAG]  = flagTap_s && !Rx_FlagDetect;
         errNow_s[CHK_SPUR]  = Rx_FlagDetect && !flagTap_s;
         errNow_s[CHK_ABORT] = abortTap_s && !Rx_AbortSignal;
         errNow_s[CHK_IDLE]  = idleArmed_r && (DataOut != capture_r);
      end else begin
         errNow_s = '0;
      end
      totSum_s = {1'b0, ErrCntTotal} + (CNT_W+3)'(popCount4(errNow_s));
   end

   // Rx history keeps shifting even while disabled so a flag straddling Enable rising is seen.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         history_r <= '0;
      end else begin
         history_r <= window_s;
      end
   end

   hdlc_mon_delay #(.DEPTH(FLAG_LATENCY)) uFlagDelay (
      .Clk   (Clk),
      .Rst   (Rst),
      .Flush (flush_s),
      .Din   (flagHit_s),
      .Dout  (flagTap_s)
   );

   hdlc_mon_delay #(.DEPTH(ABORT_LATENCY)) uAbortDelay (
      .Clk   (Clk),
      .Rst   (Rst),
      .Flush (flush_s),
      .Din   (abortReq_s),
      .Dout  (abortTap_s)
   );

   // Idle tracker: arm once per run of IDLE_LEN ones, disarm on first DataOut change.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         idleCnt_r   <= '0;
         idleArmed_r <= 1'b0;
         capture_r   <= '0;
      end else if (!Enable || !Rx) begin
         idleCnt_r   <= '0;
         idleArmed_r <= 1'b0;
      end else begin
         if (idleCnt_r != IDLE_MAX) begin
            idleCnt_r <= idleCnt_r + IDLE_CW'(1'b1);
         end
         if (idleCnt_r == (IDLE_MAX - IDLE_CW'(1'b1))) begin
            capture_r   <= DataOut;
            idleArmed_r <= 1'b1;
         end else if (errNow_s[CHK_IDLE]) begin
            idleArmed_r <= 1'b0;
         end
      end
   end

   // Error strobe, sticky bits and saturating counters; ClearCnt drops this cycle's counts.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ErrPulse    <= '0;
         ErrSticky   <= '0;
         ErrCntFlag  <= '0;
         ErrCntSpur  <= '0;
         ErrCntAbort <= '0;
         ErrCntIdle  <= '0;
         ErrCntTotal <= '0;
      end else begin
         ErrPulse <= errNow_s;
         if (ClearCnt) begin
            ErrSticky   <= '0;
            ErrCntFlag  <= '0;
            ErrCntSpur  <= '0;
            ErrCntAbort <= '0;
            ErrCntIdle  <= '0;
            ErrCntTotal <= '0;
         end else begin
            ErrSticky   <= ErrSticky | errNow_s;
            ErrCntFlag  <= satInc(ErrCntFlag,  errNow_s[CHK_FLAG]);
            ErrCntSpur  <= satInc(ErrCntSpur,  errNow_s[CHK_SPUR]);
            ErrCntAbort <= satInc(ErrCntAbort, errNow_s[CHK_ABORT]);
            ErrCntIdle  <= satInc(ErrCntIdle,  errNow_s[CHK_IDLE]);
            ErrCntTotal <= totSum_s[CNT_W+2] ? '1 : totSum_s[CNT_W+1:0];
         end
      end
   end

`ifdef HDLC_MON_TIMESTAMP_EN
   logic [31:0] cycleCnt_r;
   logic        firstLatched_r;

   // Free-running cycle count and one-shot capture of the first error after reset/clear.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cycleCnt_r     <= '0;
         firstLatched_r <= 1'b0;
         FirstErrCycle  <= '0;
         FirstErrId     <= '0;
      end else begin
         cycleCnt_r <= cycleCnt_r + 32'd1;
         if (ClearCnt) begin
            firstLatched_r <= 1'b0;
         end else if (!firstLatched_r && (errNow_s != '0)) begin
            firstLatched_r <= 1'b1;
            FirstErrCycle  <= cycleCnt_r;
            FirstErrId     <= lowestErr(errNow_s);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Self-checking bench for hdlc_rx_monitor: directed table, hand sequences, randomized run vs. reference model.
module tb_hdlc_rx_monitor;

   localparam int CNT_W = 4;
   localparam int DATA_W = 32;
   localparam int FL = 2;
   localparam int AL = 1;
   localparam int IL = 8;
   localparam int MAXC = 8192;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   logic Enable = 1'b0, ClearCnt = 1'b0, Rx = 1'b0;
   logic Rx_FlagDetect = 1'b0, Rx_ValidFrame = 1'b0, Rx_AbortDetect = 1'b0, Rx_AbortSignal = 1'b0;
   logic [DATA_W-1:0] DataOut = '0;
   logic [3:0] ErrPulse, ErrSticky;
   logic [CNT_W-1:0] ErrCntFlag, ErrCntSpur, ErrCntAbort, ErrCntIdle;
   logic [CNT_W+1:0] ErrCntTotal;
`ifdef HDLC_MON_TIMESTAMP_EN
   logic [31:0] FirstErrCycle;
   logic [1:0] FirstErrId;
`endif

   hdlc_rx_monitor #(.FLAG_LATENCY(FL), .ABORT_LATENCY(AL), .IDLE_LEN(IL), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .ClearCnt(ClearCnt), .Rx(Rx),
      .Rx_FlagDetect(Rx_FlagDetect), .Rx_ValidFrame(Rx_ValidFrame), .Rx_AbortDetect(Rx_AbortDetect),
      .Rx_AbortSignal(Rx_AbortSignal), .DataOut(DataOut), .ErrPulse(ErrPulse), .ErrSticky(ErrSticky),
      .ErrCntFlag(ErrCntFlag), .ErrCntSpur(ErrCntSpur), .ErrCntAbort(ErrCntAbort), .ErrCntIdle(ErrCntIdle),
      .ErrCntTotal(ErrCntTotal)
`ifdef HDLC_MON_TIMESTAMP_EN
      , .FirstErrCycle(FirstErrCycle), .FirstErrId(FirstErrId)
`endif
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Recorded history of everything the monitor saw, one entry per clock cycle.
   bit mRx[MAXC], mEn[MAXC], mFd[MAXC], mAb[MAXC], mAs[MAXC], mRst[MAXC];
   logic [DATA_W-1:0] mDat[MAXC];
   int n = 0;
   bit [7:0] patV = 8'h7E;

   int eCnt[4];
   int eTot;
   logic [3:0] eSticky, ePulse;
`ifdef HDLC_MON_TIMESTAMP_EN
   int mCyc;
   bit eLat;
   int eFirstCyc;
   int eFirstId;
`endif

   function automatic bit live(int i);
      return (i >= 0) && !mRst[i] && mEn[i];
   endfunction

   function automatic bit smp(int i);
      if (i < 0) return 1'b0;
      if (mRst[i]) return 1'b0;
      return mRx[i];
   endfunction

   function automatic bit flagHit(int t);
      for (int k = 0; k < 8; k++)
         if (smp(t - 7 + k) != patV[7 - k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit windowOk(int from, int to);
      for (int i = from; i <= to; i++)
         if (!live(i)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit flagTap(int t);
      if (t - FL < 0) return 1'b0;
      return flagHit(t - FL) && windowOk(t - FL, t - 1);
   endfunction

   function automatic bit abortTap(int t);
      if (t - AL < 0) return 1'b0;
      return mAb[t - AL] && windowOk(t - AL, t - 1);
   endfunction

   // Idle error: first DataOut change after the IDLE_LEN-th consecutive enabled one of the current run.
   function automatic bit idleErr(int t);
      int b, a;
      b = t - 1;
      while (b >= 0 && live(b) && smp(b)) b--;
      a = b + IL;
      if (a > t - 1) return 1'b0;
      for (int i = a + 1; i < t; i++)
         if (mDat[i] != mDat[a]) return 1'b0;
      return mDat[t] != mDat[a];
   endfunction

   function automatic logic [3:0] expPulse(int t);
      logic [3:0] p;
      bit ft;
      p = 4'b0000;
      if (!live(t)) return p;
      ft = flagTap(t);
      p[0] = ft && !mFd[t];
      p[1] = mFd[t] && !ft;
      p[2] = abortTap(t) && !mAs[t];
      p[3] = idleErr(t);
      return p;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: actual=%0h required=%0h", nm, n, act, exp);
      end
   endtask

   task automatic checkAll();
      chk("ErrPulse", 64'(ErrPulse), 64'(ePulse));
      chk("ErrSticky", 64'(ErrSticky), 64'(eSticky));
      chk("ErrCntFlag", 64'(ErrCntFlag), 64'(eCnt[0]));
      chk("ErrCntSpur", 64'(ErrCntSpur), 64'(eCnt[1]));
      chk("ErrCntAbort", 64'(ErrCntAbort), 64'(eCnt[2]));
      chk("ErrCntIdle", 64'(ErrCntIdle), 64'(eCnt[3]));
      chk("ErrCntTotal", 64'(ErrCntTotal), 64'(eTot));
`ifdef HDLC_MON_TIMESTAMP_EN
      chk("FirstErrCycle", 64'(FirstErrCycle), 64'(eFirstCyc));
      chk("FirstErrId", 64'(FirstErrId), 64'(eFirstId));
`endif
   endtask

   task automatic guard();
      if (n >= MAXC - 1) begin
         $display("FAIL history_overflow: actual=%0d required<%0d", n, MAXC - 1);
         $fatal(1, "history buffer exhausted");
      end
   endtask

   task automatic rstCyc();
      guard();
      Rst = 1'b1;
      mRst[n] = 1'b1; mRx[n] = 1'b0; mEn[n] = 1'b0; mFd[n] = 1'b0; mAb[n] = 1'b0; mAs[n] = 1'b0; mDat[n] = DataOut;
      @(posedge Clk);
      for (int k = 0; k < 4; k++) eCnt[k] = 0;
      eTot = 0; eSticky = 4'b0000; ePulse = 4'b0000;
`ifdef HDLC_MON_TIMESTAMP_EN
      mCyc = 0; eLat = 1'b0; eFirstCyc = 0; eFirstId = 0;
`endif
      #1 checkAll();
      n++;
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   task automatic cyc(input bit rx, input bit fd, input bit vf, input bit ad, input bit asig,
                      input bit en, input bit clr);
      logic [3:0] p;
      guard();
      Rx = rx; Rx_FlagDetect = fd; Rx_ValidFrame = vf; Rx_AbortDetect = ad; Rx_AbortSignal = asig;
      Enable = en; ClearCnt = clr;
      mRst[n] = 1'b0; mRx[n] = rx; mEn[n] = en; mFd[n] = fd; mAb[n] = ad && vf; mAs[n] = asig; mDat[n] = DataOut;
      @(posedge Clk);
      p = expPulse(n);
      ePulse = p;
      if (clr) begin
         for (int k = 0; k < 4; k++) eCnt[k] = 0;
         eTot = 0; eSticky = 4'b0000;
      end else begin
         for (int k = 0; k < 4; k++)
            if (p[k] && eCnt[k] < (1 << CNT_W) - 1) eCnt[k]++;
         eTot = eTot + int'(p[0]) + int'(p[1]) + int'(p[2]) + int'(p[3]);
         if (eTot > (1 << (CNT_W + 2)) - 1) eTot = (1 << (CNT_W + 2)) - 1;
         eSticky = eSticky | p;
      end
`ifdef HDLC_MON_TIMESTAMP_EN
      if (clr) eLat = 1'b0;
      else if (!eLat && p != 4'b0000) begin
         eLat = 1'b1;
         eFirstCyc = mCyc;
         eFirstId = p[0] ? 0 : p[1] ? 1 : p[2] ? 2 : 3;
      end
      mCyc++;
`endif
      #1 checkAll();
      n++;
      @(negedge Clk);
   endtask

   task automatic quiet(input int k, input bit rx);
      for (int i = 0; i < k; i++) cyc(rx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   typedef struct {
      bit rx;
      bit fd;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl[26];
   bit secRx[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   bit rq[$];

   initial begin
      // Flag latency table: section A answers 2 cycles after the last 0, section B 3 cycles after.
      for (int i = 0; i < 13; i++) begin
         tbl[i]      = '{rx: secRx[i], fd: (i == 10), exp: 4'b0000};
         tbl[13 + i] = '{rx: secRx[i], fd: (i == 11), exp: 4'b0000};
      end
      tbl[23].exp = 4'b0001;
      tbl[24].exp = 4'b0010;

      @(negedge Clk);
      rstCyc();
      rstCyc();
      for (int i = 0; i < 26; i++) begin
         cyc(tbl[i].rx, tbl[i].fd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         chk("tbl_pulse", 64'(ErrPulse), 64'(tbl[i].exp));
         if (i == 12) chk("tblA_total", 64'(ErrCntTotal), 64'd0);
      end
      chk("tbl_cnt_flag", 64'(ErrCntFlag), 64'd1);
      chk("tbl_cnt_spur", 64'(ErrCntSpur), 64'd1);
      chk("tbl_cnt_total", 64'(ErrCntTotal), 64'd2);

      // Abort with valid frame and no AbortSignal, then abort outside a frame.
      rstCyc();
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      quiet(2, 1'b0);
      chk("abort_cnt", 64'(ErrCntAbort), 64'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      quiet(2, 1'b0);
      chk("abort_novalid", 64'(ErrCntAbort), 64'd1);

      // Idle stability: change after arming is an error, change before arming is not.
      for (int pass = 0; pass < 2; pass++) begin
         rstCyc();
         DataOut = 32'hFF;
         quiet(1, 1'b0);
         for (int c = 1; c <= 12; c++) begin
            if (c == (pass == 0 ? 10 : 5)) DataOut = 32'h00;
            quiet(1, 1'b1);
         end
         quiet(1, 1'b0);
         chk(pass == 0 ? "idle_late_change" : "idle_early_change", 64'(ErrCntIdle), pass == 0 ? 64'd1 : 64'd0);
      end

      // 2^CNT_W+3 overlapping flags with no FlagDetect, then ClearCnt on a miss.
      rstCyc();
      quiet(1, 1'b0);
      for (int f = 0; f < (1 << CNT_W) + 3; f++) begin
         quiet(6, 1'b1);
         quiet(1, 1'b0);
      end
      quiet(3, 1'b0);
      chk("sat_flag", 64'(ErrCntFlag), 64'((1 << CNT_W) - 1));
      chk("sat_total", 64'(ErrCntTotal), 64'((1 << CNT_W) + 3));
      quiet(6, 1'b1);
      quiet(2, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("clr_pulse", 64'(ErrPulse), 64'd1);
      chk("clr_flag", 64'(ErrCntFlag), 64'd0);
      chk("clr_sticky", 64'(ErrSticky), 64'd0);

      // Flag completing one cycle after Enable rises is still expected.
      rstCyc();
      for (int i = 0; i < 7; i++) cyc(i != 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      quiet(3, 1'b0);
      chk("enable_edge_flag", 64'(ErrCntFlag), 64'd1);

      // Reset one cycle after a flag's last 0 cancels its expectation.
      rstCyc();
      quiet(1, 1'b0);
      quiet(6, 1'b1);
      quiet(1, 1'b0);
      rstCyc();
      quiet(4, 1'b0);
      chk("rst_midframe", 64'(ErrCntFlag), 64'd0);

`ifdef HDLC_MON_TIMESTAMP_EN
      rstCyc();
      quiet(100, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      quiet(2, 1'b0);
      chk("ts_cycle", 64'(FirstErrCycle), 64'd100);
      chk("ts_id", 64'(FirstErrId), 64'd1);
`endif

      // Randomized traffic against the reference model.
      rstCyc();
      for (int c = 0; c < 1500; c++) begin
         bit fd, asig, en;
         if (rq.size() == 0) begin
            case ($urandom_range(0, 3))
               0: begin rq.push_back(1'b0); repeat (6) rq.push_back(1'b1); rq.push_back(1'b0); end
               1: repeat ($urandom_range(6, 14)) rq.push_back(1'b1);
               2: repeat (4) rq.push_back(1'($urandom_range(0, 1)));
               default: begin rq.push_back(1'b0); rq.push_back(1'b0); end
            endcase
         end
         if ($urandom_range(0, 399) == 0) rstCyc();
         else begin
            if ($urandom_range(0, 11) == 0) DataOut = $urandom;
            fd   = flagTap(n) ^ ($urandom_range(0, 9) == 0);
            asig = abortTap(n) ^ ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 49) != 0);
            cyc(rq.pop_front(), fd, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), asig, en,
                ($urandom_range(0, 99) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hdlc_rx_monitor.md
Name: hdlc_rx_monitor

Overview:
- Synthesizable, parametrised protocol monitor for the HDLC Rx path. It replaces bench-only concurrent assertions with RTL checkers.
- Observes the serial Rx line and the Rx status outputs and checks four things: flag-detect latency, spurious flag detects, abort signalling, and DataOut stability while idle.
- Keeps per-check saturating error counters and sticky flags, readable by the testbench or by a debug register bank.

Parameters:
- FLAG_LATENCY, 2, cycles from the last flag bit sampled on Rx to the required Rx_FlagDetect (range 1..8).
- ABORT_LATENCY, 1, cycles from (Rx_AbortDetect && Rx_ValidFrame) to the required Rx_AbortSignal (range 1..8).
- IDLE_LEN, 8, consecutive Rx=1 samples that constitute idle.
- DATA_W, 32, width of DataOut.
- CNT_W, 16, width of each error counter.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Enable  in  1  checking enabled; 0 flushes all pending expectations.
- ClearCnt  in  1  synchronous clear of counters and sticky bits.
- Rx  in  1  serial receive line.
- Rx_FlagDetect  in  1  DUT flag-detect strobe.
- Rx_ValidFrame  in  1  DUT valid-frame indicator.
- Rx_AbortDetect  in  1  DUT abort-detect strobe.
- Rx_AbortSignal  in  1  DUT abort output.
- DataOut  in  DATA_W  DUT data output.
- ErrPulse  out  4  one-cycle error strobe per check; bits are [0]=flag-miss, [1]=spurious-flag, [2]=abort, [3]=idle.
- ErrSticky  out  4  sticky OR of ErrPulse.
- ErrCntFlag, ErrCntSpur, ErrCntAbort, ErrCntIdle  out  CNT_W each  per-check counters.
- ErrCntTotal  out  CNT_W+2  sum of all four error events.

Behaviour:
- Reset: every output, the 8-bit history register, the delay lines, the idle counter and the idle capture register go to 0.
- History: an 8-bit shift register samples Rx every cycle (while Enable=1, or always? — always, every cycle). flag_hit is asserted in cycle t when Rx over t-7..t equals 0,1,1,1,1,1,1,0 (8'h7E).
  - Overlapping flags that share a 0 (0111111001111110) produce two hits.
- Flag-miss (check 0): flag_hit enters a FLAG_LATENCY-deep delay line. When the tap is 1 and Rx_FlagDetect=0, ErrPulse[0] fires in that cycle.
- Spurious flag (check 1): Rx_FlagDetect=1 while the flag tap is 0 fires ErrPulse[1].
- Abort (check 2): (Rx_AbortDetect && Rx_ValidFrame) enters an ABORT_LATENCY-deep delay line. When the tap is 1 and Rx_AbortSignal=0, ErrPulse[2] fires. An AbortDetect while ValidFrame=0 is ignored.
- Idle (check 3):
  - A consecutive-ones counter saturates at IDLE_LEN; Rx=0 resets it to 0.
  - On reaching IDLE_LEN, DataOut is captured and the checker arms.
  - While armed, DataOut != capture fires ErrPulse[3] once and disarms until the next idle period.
  - Rx=0 disarms.
- Enable=0: both delay lines, the idle counter and the armed bit clear, and ErrPulse is forced to 0. The history register keeps shifting, so a flag that completes one cycle after Enable rises is still caught. Counters hold their values.
- Counters: each increments on its ErrPulse bit and saturates at all-ones. ErrCntTotal adds the popcount of ErrPulse and saturates.
- ClearCnt: has priority over a same-cycle error. The counters and ErrSticky clear, and that cycle's errors are dropped from counts and sticky bits. ErrPulse is still driven.
- Reset mid-frame: all pending expectations are lost. No error is raised for flags whose latency window spans the reset.
- Latency: ErrPulse is registered, one cycle after the violating cycle. Counters and sticky bits update in the same edge as ErrPulse.

Optional Feature:
- HDLC_MON_TIMESTAMP_EN defined:
  - Adds a free-running 32-bit cycle counter (cleared by Rst).
  - Adds outputs FirstErrCycle [31:0] and FirstErrId [1:0], latched on the first ErrPulse after reset or ClearCnt. When several bits fire at once, the lowest index wins.
  - ClearCnt re-arms the latch.
- Undefined: no cycle counter and no extra ports.

Decomposition:
- Package hdlc_mon_pkg holds:
  - FLAG_PATTERN = 8'h7E.
  - Enum chk_e {CHK_FLAG=0, CHK_SPUR=1, CHK_ABORT=2, CHK_IDLE=3}.
  - NUM_CHECKS = 4.
- Sub-module hdlc_mon_delay: a DEPTH-parameterised 1-bit delay line with a synchronous flush input and asynchronous reset. It is instantiated twice, once for flags and once for aborts.

Test Plan:
- Rx=0111_1110 with Rx_FlagDetect pulsed 2 cycles after the last 0 -> ErrPulse=0, all counters 0.
- Same Rx pattern, Rx_FlagDetect pulsed 3 cycles after -> ErrPulse[0] then ErrPulse[1]; ErrCntFlag=1, ErrCntSpur=1, ErrCntTotal=2.
- Rx_AbortDetect=1 and Rx_ValidFrame=1, Rx_AbortSignal held 0 -> ErrCntAbort=1. Repeated with ValidFrame=0 -> no error.
- Rx=1 for 12 cycles with DataOut changing 32'hFF -> 32'h00 at cycle 10 -> one ErrPulse[3], ErrCntIdle=1. Changing at cycle 5 -> no error.
- Force 2^CNT_W+3 flag misses -> ErrCntFlag saturates at all-ones. Then ClearCnt coinciding with a miss -> counters 0, ErrSticky 0.
- Rst asserted 1 cycle after a flag's last 0 -> no flag-miss after release. With HDLC_MON_TIMESTAMP_EN, a first error at cycle 100 -> FirstErrCycle=100 and FirstErrId=the index of the failing check.
